// File: rtl/parity_decoder_module_if.sv
// ----------------------------------------------------------------------------
// parity_decoder_module_if
//
// Purpose : Groups the input and output flit handshakes of the parity decoder
//           so that the decoder and its environment connect through a single
//           port.
//
// Parameters:
//   FLIT_WIDTH  payload width in bits (multiple of 8)
//
// Signals:
//   in_flit    [FLIT_WIDTH/8+FLIT_WIDTH-1:0]  encoded flit, parity bits in MSBs
//   in_valid                                  in_flit is valid
//   in_ready                                  decoder accepts in_flit
//   out_flit   [FLIT_WIDTH-1:0]               payload, parity bits removed
//   out_valid                                 out_flit is valid
//   out_ready                                 downstream accepts out_flit
//   out_error                                 held flit failed its parity check
//
// Modports:
//   slave   the decoder's view (consumes in_*, produces out_*)
//   master  the environment's view (produces in_*, consumes out_*)
// ----------------------------------------------------------------------------
interface parity_decoder_module_if #(
    parameter int FLIT_WIDTH = 32
);
    localparam int PARITY_BITS = FLIT_WIDTH / 8;

    logic [PARITY_BITS+FLIT_WIDTH-1:0] in_flit;
    logic                              in_valid;
    logic                              in_ready;
    logic [FLIT_WIDTH-1:0]             out_flit;
    logic                              out_valid;
    logic                              out_ready;
    logic                              out_error;

    modport slave (
        input  in_flit,
        input  in_valid,
        output in_ready,
        output out_flit,
        output out_valid,
        input  out_ready,
        output out_error
    );

    modport master (
        output in_flit,
        output in_valid,
        input  in_ready,
        input  out_flit,
        input  out_valid,
        output out_ready,
        input  out_error
    );
endinterface

// File: rtl/parity_decoder_module.sv
// ----------------------------------------------------------------------------
// parity_decoder_module
//
// Purpose : Checks odd parity on every payload byte of an incoming flit,
//           strips the parity bits and forwards the payload (unchanged, even
//           when erroneous) through a single valid/ready register stage.
//           Keeps sticky per-byte error flags and an OK/FAULT status.
//
// Parameters:
//   FLIT_WIDTH  payload width in bits, multiple of 8 (default 32)
//   CNT_WIDTH   width of the optional error counter (default 16)
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active-high
//   bus         parity_decoder_module_if.slave (in/out flit handshakes)
//   err_clear   single-cycle pulse clearing the sticky status
//   err_bytes   sticky per-byte parity error flags
//   err_state   0 = OK, 1 = FAULT
//   err_count   saturating count of erroneous flits
//               (only when PARITY_DECODER_ERR_COUNTER_EN is defined)
//
// Build option:
//   PARITY_DECODER_ERR_COUNTER_EN  adds the err_count port and its counter.
// ----------------------------------------------------------------------------
module parity_decoder_module #(
    parameter int FLIT_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    parity_decoder_module_if.slave    bus,
    input  logic                      err_clear,
    output logic [FLIT_WIDTH/8-1:0]   err_bytes,
    output logic                      err_state
`ifdef PARITY_DECODER_ERR_COUNTER_EN
    ,
    output logic [CNT_WIDTH-1:0]      err_count
`endif
);
    localparam int PARITY_BITS = FLIT_WIDTH / 8;

    typedef enum logic {
        ST_OK    = 1'b0,
        ST_FAULT = 1'b1
    } err_state_e;

    // ------------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------------
    if (FLIT_WIDTH % 8 != 0) begin : g_bad_flit_width
        $fatal(1, "parity_decoder_module: FLIT_WIDTH must be a multiple of 8");
    end

    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $fatal(1, "parity_decoder_module: CNT_WIDTH must be at least 1");
    end

    // ------------------------------------------------------------------------
    // Parity check and handshake
    // ------------------------------------------------------------------------
    logic [PARITY_BITS-1:0] byte_err;
    logic                   flit_err;
    logic                   in_fire;
    logic                   out_fire;
    logic                   err_accept;

    // Odd parity: a byte plus its parity bit must hold an odd number of ones,
    // so an XOR of 0 over the nine bits marks the byte as bad.
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        byte_err = '0;
        for (int b = 0; b < PARITY_BITS; b++) begin
            byte_err[b] = ~(^{bus.in_flit[FLIT_WIDTH+b], bus.in_flit[8*b +: 8]});
        end
    end

    logic                  out_valid_q, out_valid_d;
    logic [FLIT_WIDTH-1:0] out_flit_q,  out_flit_d;
    logic                  out_error_q, out_error_d;

    // Ready only looks at the output register and downstream ready, never at
    // in_valid, so no combinational loop can form through the handshake.
    assign bus.in_ready = ~out_valid_q | bus.out_ready;

    assign flit_err   = |byte_err;
    assign in_fire    = bus.in_valid & bus.in_ready;
    assign out_fire   = out_valid_q & bus.out_ready;
    assign err_accept = in_fire & flit_err;

    // ------------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        out_error_d = out_error_q;
        if (in_fire) begin
            // Covers the simultaneous in/out transfer case: the new flit
            // simply overwrites the one leaving, giving full throughput.
            out_valid_d = 1'b1;
            out_flit_d  = bus.in_flit[FLIT_WIDTH-1:0];
            out_error_d = flit_err;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky status FSM and per-byte flags
    // ------------------------------------------------------------------------
    err_state_e             state_q,     state_d;
    logic [PARITY_BITS-1:0] err_bytes_q, err_bytes_d;

    // Clear is applied before the new error so a clear coinciding with an
    // erroneous acceptance leaves exactly that flit's error vector.
    always_comb begin
        state_d     = state_q;
        err_bytes_d = err_bytes_q;
        if (err_clear) begin
            state_d     = ST_OK;
            err_bytes_d = '0;
        end
        if (err_accept) begin
            state_d     = ST_FAULT;
            err_bytes_d = err_bytes_d | byte_err;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample
    // their _d values from the same edge regardless of block ordering.
    // NOTE: the payload register is reset as well because out_flit must read
    // zero during and after reset, not just be qualified by out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_error_q <= 1'b0;
            state_q     <= ST_OK;
            err_bytes_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_error_q <= out_error_d;
            state_q     <= state_d;
            err_bytes_q <= err_bytes_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_flit  = out_flit_q;
    assign bus.out_error = out_error_q;
    assign err_bytes     = err_bytes_q;
    assign err_state     = (state_q == ST_FAULT);

    // ------------------------------------------------------------------------
    // Optional saturating error counter
    // ------------------------------------------------------------------------
`ifdef PARITY_DECODER_ERR_COUNTER_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic [CNT_WIDTH-1:0] cnt_base;

    // Same ordering as the flags: clear first, then count, so a clear with an
    // erroneous acceptance yields 1.
    always_comb begin
        cnt_base    = err_clear ? '0 : err_count_q;
        err_count_d = cnt_base;
        if (err_accept && (cnt_base != CNT_MAX)) begin
            err_count_d = cnt_base + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_parity_decoder_module.sv
// ----------------------------------------------------------------------------
// tb_parity_decoder_module
//
// Purpose : Self-checking bench for parity_decoder_module (FLIT_WIDTH=32,
//           CNT_WIDTH=2). Directed scenarios followed by randomized traffic,
//           all compared against a transaction-level reference model: a
//           queue holding at most one in-flight flit, plus sticky flags and a
//           saturating counter computed from popcounts.
//
// Build option:
//   PARITY_DECODER_ERR_COUNTER_EN  also connects and checks err_count.
// ----------------------------------------------------------------------------
module tb_parity_decoder_module;
    localparam int FW     = 32;
    localparam int PB     = FW / 8;
    localparam int CW     = 2;
    localparam int CNT_MX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          err_clear;
    logic [PB-1:0] err_bytes;
    logic          err_state;
`ifdef PARITY_DECODER_ERR_COUNTER_EN
    logic [CW-1:0] err_count;
`endif

    parity_decoder_module_if #(.FLIT_WIDTH(FW)) bus ();

    parity_decoder_module #(
        .FLIT_WIDTH (FW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .err_clear  (err_clear),
        .err_bytes  (err_bytes),
        .err_state  (err_state)
`ifdef PARITY_DECODER_ERR_COUNTER_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct {
        logic [FW-1:0] payload;
        logic          err;
    } held_t;

    held_t         held_q[$];
    logic [PB-1:0] m_flags;
    bit            m_fault;
    int            m_count;

    // A byte is bad when byte plus parity bit has an even number of ones.
    function automatic logic [PB-1:0] err_vec(input logic [FW+PB-1:0] f);
        logic [PB-1:0] v;
        int ones;
        v = '0;
        for (int b = 0; b < PB; b++) begin
            ones = $countones(f[8*b +: 8]) + int'(f[FW+b]);
            v[b] = (ones % 2 == 0);
        end
        return v;
    endfunction

    // Builds a flit with correct parity, then inverts the parity bits in flip.
    function automatic logic [FW+PB-1:0] make_flit(input logic [FW-1:0] payload,
                                                   input logic [PB-1:0] flip);
        logic [PB-1:0] p;
        for (int b = 0; b < PB; b++) begin
            p[b] = ($countones(payload[8*b +: 8]) % 2 == 0);
        end
        return {p ^ flip, payload};
    endfunction

    // One clock cycle: drive on the falling edge, check in_ready, let the
    // rising edge happen, advance the model, then check the registered state.
    task automatic cycle(input logic [FW+PB-1:0] flit, input bit valid,
                         input bit ready, input bit clr, input bit do_rst);
        bit            exp_ready;
        bit            accept;
        logic [PB-1:0] ev;
        @(negedge clk);
        bus.in_flit   = flit;
        bus.in_valid  = valid;
        bus.out_ready = ready;
        err_clear     = clr;
        rst           = do_rst;
        #1;
        exp_ready = (held_q.size() == 0) || ready;
        check("in_ready", bus.in_ready, exp_ready);
        @(posedge clk);
        if (do_rst) begin
            held_q.delete();
            m_flags = '0;
            m_fault = 1'b0;
            m_count = 0;
        end else begin
            accept = valid && exp_ready;
            ev     = err_vec(flit);
            if (ready && held_q.size() != 0) void'(held_q.pop_front());
            if (accept) held_q.push_back('{payload: flit[FW-1:0], err: (ev != '0)});
            if (clr) begin
                m_flags = '0;
                m_fault = 1'b0;
                m_count = 0;
            end
            if (accept && ev != '0) begin
                m_flags = m_flags | ev;
                m_fault = 1'b1;
                if (m_count < CNT_MX) m_count++;
            end
        end
        #1;
        check("out_valid", bus.out_valid, held_q.size() != 0);
        if (held_q.size() != 0) begin
            check("out_flit", bus.out_flit, held_q[0].payload);
            check("out_error", bus.out_error, held_q[0].err);
        end else if (do_rst) begin
            check("rst_out_flit", bus.out_flit, '0);
            check("rst_out_error", bus.out_error, 1'b0);
        end
        check("err_bytes", err_bytes, m_flags);
        check("err_state", err_state, m_fault);
`ifdef PARITY_DECODER_ERR_COUNTER_EN
        check("err_count", err_count, m_count);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [FW+PB-1:0] f;
        logic [PB-1:0]    flip;
        rst           = 1'b1;
        err_clear     = 1'b0;
        bus.in_flit   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        m_flags       = '0;
        m_fault       = 1'b0;
        m_count       = 0;

        // Reset, then the first idle cycle must be ready.
        cycle('0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle('0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Clean all-zero flit, then byte1 corrupted.
        cycle(36'hF_00000000, 1'b1, 1'b1, 1'b0, 1'b0);
        check("clean_state", err_state, 1'b0);
        cycle(36'hF_00000100, 1'b1, 1'b1, 1'b0, 1'b0);
        check("byte1_flags", err_bytes, 4'b0010);
        check("byte1_error", bus.out_error, 1'b1);
        cycle('0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Stall for three cycles with a new flit offered, then back-to-back.
        cycle(make_flit(32'hA5A5_0001, '0), 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(make_flit(32'h1234_5678, '0), 1'b1, 1'b0, 1'b0, 1'b0);
            check("stall_flit", bus.out_flit, 32'hA5A5_0001);
        end
        cycle(make_flit(32'h1234_5678, '0), 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(make_flit(32'hDEAD_BEEF, 4'b0001), 1'b1, 1'b1, 1'b0, 1'b0);
        check("b2b_flit", bus.out_flit, 32'hDEAD_BEEF);
        cycle('0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Clear coinciding with a byte3 error: flags hold only that flit's.
        cycle(make_flit(32'h0000_00FF, 4'b0011), 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(36'h7_00000000, 1'b1, 1'b1, 1'b1, 1'b0);
        check("clr_err_flags", err_bytes, 4'b1000);
        check("clr_err_state", err_state, 1'b1);

        // Five erroneous flits saturate a 2-bit counter at 3.
        cycle('0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(make_flit(32'($urandom), 4'b0100), 1'b1, 1'b1, 1'b0, 1'b0);
        end

        // Reset while a flit is held mid-handshake.
        cycle(make_flit(32'hCAFE_F00D, 4'b1111), 1'b1, 1'b1, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_held_valid", bus.out_valid, 1'b0);
        check("rst_held_flags", err_bytes, '0);
        cycle('0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            flip = ($urandom_range(0, 2) == 0) ? PB'($urandom) : '0;
            f    = make_flit(32'($urandom), flip);
            cycle(f, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/parity_decoder_module.md
PARITY_DECODER_MODULE -- requirements
Module: parity_decoder_module

Interface
REQ-001: Parameter FLIT_WIDTH, default 32, payload width in bits; multiple of 8.
REQ-002: Parameter CNT_WIDTH, default 16, width of the error counter.
REQ-003: Derived constant PARITY_BITS = FLIT_WIDTH/8, one parity bit per payload byte.
REQ-004: clk  in  1  single clock; every register is updated on the rising edge.
REQ-005: rst  in  1  synchronous reset, active-high.
REQ-006: in_flit  in  PARITY_BITS+FLIT_WIDTH  encoded flit; parity bits sit in the MSBs above the payload.
REQ-007: in_valid  in  1  in_flit is valid.
REQ-008: in_ready  out  1  module accepts in_flit this cycle.
REQ-009: out_flit  out  FLIT_WIDTH  payload with the parity bits removed.
REQ-010: out_valid  out  1  out_flit is valid.
REQ-011: out_ready  in  1  downstream accepts out_flit.
REQ-012: out_error  out  1  the flit held in out_flit failed its parity check.
REQ-013: err_bytes  out  PARITY_BITS  sticky per-byte error flags.
REQ-014: err_state  out  1  0 = OK, 1 = FAULT.
REQ-015: err_clear  in  1  single-cycle pulse that clears the sticky status.
REQ-016: err_count  out  CNT_WIDTH  count of erroneous flits; present only with the macro (REQ-034).

Function
REQ-017: The parity check is odd parity. Byte b is in_flit[8b+7:8b] and its parity bit is in_flit[FLIT_WIDTH+b]. Byte b is in error when the XOR of those 9 bits is 0.
REQ-018: A flit is erroneous when at least one of its bytes is in error.
REQ-019: The data path is one output register stage. in_ready = ~out_valid | out_ready, and it depends combinationally only on out_valid and out_ready.
REQ-020: Transfer on either side occurs when valid and ready are both 1 in the same cycle.
REQ-021: An accepted flit appears on out_flit/out_error with out_valid=1 in the next cycle. Latency is exactly 1 cycle.
REQ-022: While out_valid=1 and out_ready=0, out_flit and out_error stay stable.
REQ-023: An output transfer with no input transfer in the same cycle drives out_valid to 0.
REQ-024: Simultaneous input and output transfers replace the register contents with no bubble, giving full throughput.
REQ-025: Erroneous flits are forwarded unchanged, never dropped. The payload is not corrected.
REQ-026: The status FSM moves OK->FAULT on acceptance of an erroneous flit, and FAULT->OK on err_clear when no erroneous flit is accepted in that cycle.
REQ-027: err_bytes[b] is set when a flit with byte b in error is accepted, and is cleared by err_clear.
REQ-028: If err_clear and an erroneous acceptance occur in the same cycle, the result is FAULT and err_bytes equals that flit's error vector only.
REQ-029: Parity is evaluated only on accepted flits. in_flit is ignored while in_valid=0 or in_ready=0.
REQ-030: An elaboration-time fatal error is raised when FLIT_WIDTH%8 != 0.

Reset
REQ-031: rst=1 forces out_valid=0, out_flit=0, out_error=0, err_bytes=0, err_state=OK and err_count=0.
REQ-032: rst has priority over all other inputs. A flit held mid-handshake during reset is discarded.
REQ-033: in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-034: Macro PARITY_DECODER_ERR_COUNTER_EN.
- Defined: err_count increments by 1 for each accepted erroneous flit, saturates at 2^CNT_WIDTH-1, and is cleared to 0 by err_clear.
- With err_clear and an erroneous acceptance in the same cycle, err_count = 1.
REQ-035: Without the macro, the err_count port and its logic are absent. All other behaviour is identical.

Verification (FLIT_WIDTH=32)
REQ-036: in_flit=36'hF_00000000, in_valid=1, out_ready=1 -> next cycle out_flit=32'h00000000, out_valid=1, out_error=0, err_state=OK.
REQ-037: in_flit=36'hF_00000100 (byte1 flipped) -> out_flit=32'h00000100, out_error=1, err_bytes=4'b0010, err_state=FAULT, err_count=1.
REQ-038: out_ready=0 for 3 cycles with a held flit -> out_flit stable, in_ready=0; out_ready=1 with a new in_valid -> back-to-back transfer with no bubble.
REQ-039: err_clear pulsed in the same cycle as accepting 36'h7_00000000 (byte3 error) -> err_state=FAULT, err_bytes=4'b1000, err_count=1.
REQ-040: With CNT_WIDTH=2, feed 5 erroneous flits -> err_count saturates at 3.
REQ-041: Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, err_bytes=0, in_ready=1.
